ex_mdu: RTL and testbench
=========================

# ex_mdu

Multi-cycle multiply/divide unit with the architectural HI/LO registers, sitting in the EX stage beside the ALU. It executes mult/multu/div/divu and mthi/mtlo. It exposes HI/LO for mfhi/mflo; the EX result mux forwards the selected value into the EX/MA pipeline register as the EX-stage result. It drives `busy` so the hazard unit can hold ID/EX while an operation is in flight.

## Interface
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (must be ≥1)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (must be ≥1)

- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clears all state on the posedge it is sampled
- start  in  1  launch the operation in `md_op`; meaningful only when md_op is 1–4
- md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- A  in  32  rs operand (already forwarded)
- B  in  32  rt operand (already forwarded)
- busy  out  1  registered; high while an operation is in flight
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register

## Operation
- State: IDLE / RUN. Also holds a countdown counter (width clog2(max(MULT_CYCLES, DIV_CYCLES))+1) and 32-bit staged results hi_n and lo_n.
- IDLE, start=1, md_op∈{1..4}:
  - compute the result from A, B into hi_n/lo_n
  - load the counter with MULT_CYCLES or DIV_CYCLES
  - go to RUN; busy=1
- IDLE, start=0, md_op=5 (MTHI): hi<=A. md_op=6 (MTLO): lo<=A. These take one cycle; busy stays 0.
- IDLE, start=1 with md_op∉{1..4}: start is ignored; MTHI/MTLO still act on md_op.
- RUN: decrement the counter each edge. On the edge where the counter goes 1→0:
  - hi<=hi_n, lo<=lo_n
  - busy<=0
  - go to IDLE
- RUN, any start or md_op: ignored. The hazard unit guarantees this never happens; the bench flags it as a protocol violation but the DUT must not corrupt state.
- MULT: {hi,lo} = signed 64-bit A×B. MULTU: the unsigned product.
- DIV: lo = A/B truncated toward zero; hi = remainder, taking the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned quotient in lo, unsigned remainder in hi.
- Divide by zero (B=0, DIV or DIVU): busy runs the full DIV_CYCLES; hi/lo are left unchanged at completion.
- Operands are captured at the start edge. Changes to A/B during RUN have no effect.

## Timing
- Reset values: busy=0, hi=0, lo=0, counter=0, state IDLE. hi_n/lo_n=0.
- A start sampled at edge E0 produces:
  - busy=1 during cycles E0+1 … E0+N
  - hi/lo new values and busy=0 visible after edge E0+N
  - N = MULT_CYCLES or DIV_CYCLES
- Back-to-back: start may be accepted on the same edge at which busy falls? No. At edge E0+N the unit is still RUN, so start is ignored. The earliest next accept is edge E0+N+1. The hazard unit stalls on (busy | start), which satisfies this.
- MTHI/MTLO: the write is visible the cycle after the edge.
- mfhi/mflo reads are combinational from hi/lo. During RUN they return the old values; the hazard unit must stall mf* while busy|start.
- Reset mid-RUN: the operation is abandoned. busy=0, hi=lo=0 after that edge; no completion write occurs later.
- Reset has priority over start and MTHI/MTLO on the same edge.

## Test plan
- MULT: A=0xFFFFFFFD (−3), B=5, start 1 cycle.
  - busy high exactly 5 cycles
  - then hi=0xFFFFFFFF, lo=0xFFFFFFF1
- MULTU: A=0xFFFFFFFF, B=2 → after 5 cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV: A=0xFFFFFFF9 (−7), B=2.
  - busy high exactly 10 cycles
  - then lo=0xFFFFFFFD, hi=0xFFFFFFFF
- DIVU: A=7, B=0, with prior hi=0x11, lo=0x22 set via MTHI/MTLO (each visible one cycle later).
  - busy high 10 cycles
  - hi=0x11, lo=0x22 unchanged afterwards
- Start MULT 3×4; at cycle 2 of busy, drive start with DIV and toggle A/B.
  - second start ignored
  - busy falls after 5 cycles
  - lo=12, hi=0
- Start DIVU 100/7, assert reset at busy cycle 4 → next cycle busy=0, hi=lo=0; they stay 0 through cycle 12.

Source files
------------

// File: rtl/ex_mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at launch, staged, and committed when the countdown expires.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q, hin_q, lon_q;
  logic [63:0]   res_d;
  logic          is_mul_d, launch_d;

  function automatic logic [63:0] mul_res(input logic is_signed,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'b0, a} * {32'b0, b};
    return is_signed ? sp : up;
  endfunction

  // Returns {remainder, quotient}; divide-by-zero hands back the current HI/LO.
  function automatic logic [63:0] div_res(input logic is_signed,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return {cur_hi, cur_lo};
    if (!is_signed) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sr, sq};
  endfunction

  always_comb begin
    is_mul_d = (md_op == OP_MULT) || (md_op == OP_MULTU);
    launch_d = start && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    res_d    = is_mul_d ? mul_res(md_op == OP_MULT, A, B)
                        : div_res(md_op == OP_DIV, A, B, hi_q, lo_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      hin_q   <= '0;
      lon_q   <= '0;
    end else if (state_q == IDLE) begin
      if (launch_d) begin
        {hin_q, lon_q} <= res_d;
        cnt_q   <= is_mul_d ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        busy_q  <= 1'b1;
        state_q <= RUN;
      end else if (md_op == OP_MTHI) begin
        hi_q <= A;
      end else if (md_op == OP_MTLO) begin
        lo_q <= A;
      end
    end else begin
      // Inputs are deliberately ignored while an operation is in flight.
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_q    <= hin_q;
        lo_q    <= lon_q;
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed vector table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_ex_mdu;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] m_hi, m_lo;

  ex_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          cyc;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, divide-by-zero keeps current HI/LO.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
    longint qa, qb, q, r;
    longint unsigned ua, ub;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd1: return longint'($signed(a)) * longint'($signed(b));
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 0) return cur;
        qa = longint'($signed(a));
        qb = longint'($signed(b));
        q = qa / qb;
        r = qa % qb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return cur;
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return cur;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtx(input logic [2:0] op, input logic [31:0] v, input logic st);
    start = st; md_op = op; A = v;
    step();
    start = 1'b0; md_op = 3'd0; A = $urandom;
    if (op == 3'd5) begin check("mthi", hi, v); m_hi = v; end
    else begin check("mtlo", lo, v); m_lo = v; end
    check("mtx_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    step();
    start = 1'b0; md_op = 3'd0; A = $urandom; B = $urandom;
  endtask

  // Counts busy cycles; optionally injects an illegal request in busy cycle 2.
  task automatic wait_idle(input logic [2:0] inj_op, output int n);
    n = 0;
    while (busy && n < 64) begin
      if (inj_op != 3'd0 && n == 1) begin
        $display("note: protocol violation injected (md_op=%0d during RUN)", inj_op);
        start = 1'b1; md_op = inj_op; A = $urandom; B = $urandom;
      end else begin
        start = 1'b0; md_op = 3'd0; A = $urandom; B = $urandom;
      end
      n++;
      step();
    end
    start = 1'b0; md_op = 3'd0;
  endtask

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] r;

    tbl[0] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    tbl[1] = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h0,  32'h0,  32'h00000001, 32'hFFFFFFFE, 5};
    tbl[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[3] = '{3'd4, 32'd7,        32'd0,        32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};
    tbl[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,  32'h00000000, 32'h80000000, 10};
    tbl[5] = '{3'd4, 32'd100,      32'd7,        32'h0,  32'h0,  32'h00000002, 32'h0000000E, 10};
    tbl[6] = '{3'd1, 32'h80000000, 32'h80000000, 32'h0,  32'h0,  32'h40000000, 32'h00000000, 5};
    tbl[7] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,  32'h00000001, 32'hFFFFFFFD, 10};
    tbl[8] = '{3'd3, 32'hDEAD,     32'd0,        32'hAAAA, 32'hBBBB, 32'h0000AAAA, 32'h0000BBBB, 10};

    reset = 1'b1; start = 1'b0; md_op = 3'd0; A = '0; B = '0;
    step(); step();
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;

    foreach (tbl[i]) begin
      mtx(3'd5, tbl[i].pre_hi, 1'b0);
      mtx(3'd6, tbl[i].pre_lo, 1'b0);
      launch(tbl[i].op, tbl[i].a, tbl[i].b);
      check("tbl_busy_mid", {31'b0, hi == tbl[i].pre_hi}, 32'd1);
      wait_idle(3'd0, n);
      check("tbl_cycles", n, tbl[i].cyc);
      check("tbl_hi", hi, tbl[i].exp_hi);
      check("tbl_lo", lo, tbl[i].exp_lo);
      m_hi = tbl[i].exp_hi; m_lo = tbl[i].exp_lo;
    end

    // start with a non-MD op in IDLE still performs MTHI/MTLO.
    mtx(3'd5, 32'h1234_5678, 1'b1);
    mtx(3'd6, 32'h9ABC_DEF0, 1'b1);

    // Illegal requests during RUN must not disturb the running MULT.
    launch(3'd1, 32'd3, 32'd4);
    wait_idle(3'd3, n);
    check("inj_div_cycles", n, 5);
    check("inj_div_hi", hi, 32'd0);
    check("inj_div_lo", lo, 32'd12);
    launch(3'd2, 32'd6, 32'd7);
    wait_idle(3'd5, n);
    check("inj_mthi_cycles", n, 5);
    check("inj_mthi_hi", hi, 32'd0);
    check("inj_mthi_lo", lo, 32'd42);
    m_hi = 32'd0; m_lo = 32'd42;

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      if (k % 7 == 3) b = 32'd0;
      if (k % 5 == 1) b = b >> $urandom_range(16, 31);
      if (k % 9 == 2) a = -a;
      r = ref_op(op, a, b, {m_hi, m_lo});
      launch(op, a, b);
      wait_idle(3'd0, n);
      check("rnd_cycles", n, (op <= 3'd2) ? 5 : 10);
      check("rnd_hi", hi, r[63:32]);
      check("rnd_lo", lo, r[31:0]);
      m_hi = r[63:32]; m_lo = r[31:0];
    end

    // Reset during a DIVU abandons it; no late commit may appear.
    mtx(3'd5, 32'h55, 1'b0);
    mtx(3'd6, 32'h66, 1'b0);
    launch(3'd4, 32'd100, 32'd7);
    step(); step(); step();
    check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    for (int c = 0; c < 9; c++) begin
      step();
      check("rst_hold_busy", {31'b0, busy}, 32'd0);
      check("rst_hold_hi", hi, 32'd0);
      check("rst_hold_lo", lo, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
